// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci job controller: FSM states, default
// operand width and the response entry layout.
package fib_pkg;

   localparam int unsigned FIB_DW = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CLR  = 2'd1,
      RUN  = 2'd2
   } fib_state_e;

   typedef struct packed {
      logic [FIB_DW-1:0] number;
      logic [FIB_DW-1:0] result;
      logic              err;
   } fib_rsp_t;

endpackage

// File: rtl/fib_rsp_fifo.sv
// Synchronous response FIFO with registered full/empty and a look-ahead count.
// Pop on empty is ignored; pointers wrap modulo DEPTH (power of two, >= 2).
module fib_rsp_fifo #(
   parameter int unsigned W     = 21,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   Clk,
   input  logic                   Rst_n,
   input  logic                   push,
   input  logic [W-1:0]           wr_data,
   input  logic                   pop,
   output logic [W-1:0]           rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count_nxt_c
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_pop;

   assign do_pop      = pop && !empty;
   assign count_nxt_c = count_q + CW'(push) - CW'(do_pop);
   assign rd_data     = mem[rd_ptr_q];

   // Storage cleared on reset so the head reads zero while empty.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty    <= 1'b1;
         full     <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr_q] <= wr_data;
            wr_ptr_q      <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_nxt_c;
         empty   <= (count_nxt_c == '0);
         full    <= (count_nxt_c == CW'(DEPTH));
      end
   end

endmodule

// File: rtl/fib_job_ctrl.sv
// Sequences the Fib_Seq engine through reset/start/done for one job at a time
// and queues tagged results. Define FIB_TIMEOUT_EN to enable the RUN watchdog.
module fib_job_ctrl
   import fib_pkg::*;
#(
   parameter int unsigned DW         = FIB_DW,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 1023
) (
   input  logic          Clk,
   input  logic          Rst_n,
   input  logic          ReqValid,
   output logic          ReqReady,
   input  logic [DW-1:0] ReqNumber,
   output logic          FibRst,
   output logic          FibStart,
   output logic [DW-1:0] FibNumber,
   input  logic [DW-1:0] FibResult,
   input  logic          FibDone,
   output logic          RspValid,
   input  logic          RspReady,
   output logic [DW-1:0] RspNumber,
   output logic [DW-1:0] RspResult,
   output logic          RspErr,
   output logic          Busy
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
`ifdef FIB_TIMEOUT_EN
   localparam int unsigned EW = 2*DW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
`else
   localparam int unsigned EW = 2*DW;
`endif

   fib_state_e    state_q;
   fib_state_e    state_nxt;
   logic          first_q;
   logic          accept;
   logic          push;
   logic          pop;
   logic [EW-1:0] push_data;
   logic [EW-1:0] head_data;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count_nxt;

   logic          req_ready_d;
   logic          fib_rst_d;
   logic          fib_start_d;
   logic          busy_d;
   logic [DW-1:0] fib_number_d;

`ifdef FIB_TIMEOUT_EN
   logic          push_err;
   logic [TW-1:0] run_cnt_q;
`else
   logic [31:0]   unused_timeout;
   assign unused_timeout = 32'(TIMEOUT);
`endif

   // State and registered outputs; outputs are precomputed from the next state.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q   <= IDLE;
         first_q   <= 1'b0;
         ReqReady  <= 1'b0;
         FibRst    <= 1'b0;
         FibStart  <= 1'b0;
         FibNumber <= '0;
         Busy      <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         first_q   <= (state_q == CLR);
         ReqReady  <= req_ready_d;
         FibRst    <= fib_rst_d;
         FibStart  <= fib_start_d;
         FibNumber <= fib_number_d;
         Busy      <= busy_d;
      end
   end

   // Done is stale during the first RUN cycle, so only later cycles may complete.
   always_comb begin
      state_nxt = state_q;
      accept    = 1'b0;
      push      = 1'b0;
`ifdef FIB_TIMEOUT_EN
      push_err  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (ReqValid && ReqReady) begin
               accept    = 1'b1;
               state_nxt = CLR;
            end
         end
         CLR: begin
            state_nxt = RUN;
         end
         RUN: begin
            if (!first_q && FibDone) begin
               push      = 1'b1;
               state_nxt = IDLE;
            end
`ifdef FIB_TIMEOUT_EN
            else if (run_cnt_q == TW'(TIMEOUT - 1)) begin
               push      = 1'b1;
               push_err  = 1'b1;
               state_nxt = IDLE;
            end
`endif
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Acceptance reserves a FIFO slot, judged on the post-edge occupancy.
   always_comb begin
      req_ready_d  = (state_nxt == IDLE) && (fifo_count_nxt < CW'(FIFO_DEPTH));
      fib_rst_d    = (state_nxt == CLR);
      fib_start_d  = (state_nxt == RUN);
      busy_d       = (state_nxt != IDLE);
      fib_number_d = accept ? ReqNumber : FibNumber;
   end

`ifdef FIB_TIMEOUT_EN
   // Counts completed RUN cycles of the current job.
   always_ff @(posedge Clk) begin
      if (!Rst_n || (state_q != RUN)) begin
         run_cnt_q <= '0;
      end else begin
         run_cnt_q <= run_cnt_q + TW'(1);
      end
   end

   assign push_data = {FibNumber, (push_err ? DW'(0) : FibResult), push_err};
   assign RspNumber = head_data[2*DW:DW+1];
   assign RspResult = head_data[DW:1];
   assign RspErr    = head_data[0];
`else
   assign push_data = {FibNumber, FibResult};
   assign RspNumber = head_data[2*DW-1:DW];
   assign RspResult = head_data[DW-1:0];
   assign RspErr    = 1'b0;
`endif

   assign RspValid = !fifo_empty;
   assign pop      = RspValid && RspReady;

   fib_rsp_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_rsp_fifo (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .push        (push),
      .wr_data     (push_data),
      .pop         (pop),
      .rd_data     (head_data),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .count_nxt_c (fifo_count_nxt)
   );

   // A full FIFO blocks acceptance, so a completing job always finds a free slot.
   a_no_push_full: assert property (@(posedge Clk) disable iff (!Rst_n) !(push && fifo_full));

endmodule

// File: tb/tb_fib_job_ctrl.sv
// Directed bench for fib_job_ctrl with a stub engine returning Number*2 after
// a programmable number of Start cycles; Done is held until the next FibRst.
module tb_fib_job_ctrl;

   localparam int unsigned DW = 10;

   logic          Clk       = 1'b0;
   logic          Rst_n     = 1'b0;
   logic          ReqValid  = 1'b0;
   logic          ReqReady;
   logic [DW-1:0] ReqNumber = '0;
   logic          FibRst;
   logic          FibStart;
   logic [DW-1:0] FibNumber;
   logic [DW-1:0] FibResult;
   logic          FibDone;
   logic          RspValid;
   logic          RspReady  = 1'b0;
   logic [DW-1:0] RspNumber;
   logic [DW-1:0] RspResult;
   logic          RspErr;
   logic          Busy;

   int            n_checks = 0;
   int            n_fail   = 0;

   int            stub_lat  = 1;
   int            stub_cnt  = 0;
   logic          stub_done = 1'b0;
   logic [DW-1:0] stub_res  = '0;
   logic          stale_done = 1'b0;

   assign FibDone   = stub_done | stale_done;
   assign FibResult = stub_res;

   always #5 Clk = ~Clk;

   fib_job_ctrl #(
      .DW         (DW),
      .FIFO_DEPTH (4),
      .TIMEOUT    (8)
   ) dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .ReqValid  (ReqValid),
      .ReqReady  (ReqReady),
      .ReqNumber (ReqNumber),
      .FibRst    (FibRst),
      .FibStart  (FibStart),
      .FibNumber (FibNumber),
      .FibResult (FibResult),
      .FibDone   (FibDone),
      .RspValid  (RspValid),
      .RspReady  (RspReady),
      .RspNumber (RspNumber),
      .RspResult (RspResult),
      .RspErr    (RspErr),
      .Busy      (Busy)
   );

   // Stub engine; stub_lat == 0 means it never finishes.
   always @(posedge Clk) begin
      if (FibRst === 1'b1) begin
         stub_cnt  <= 0;
         stub_done <= 1'b0;
      end else if (FibStart === 1'b1 && !stub_done && stub_lat != 0) begin
         if (stub_cnt + 1 == stub_lat) begin
            stub_done <= 1'b1;
            stub_res  <= {FibNumber[DW-2:0], 1'b0};
         end
         stub_cnt <= stub_cnt + 1;
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Rst_n = 1'b0; ReqValid = 1'b0; RspReady = 1'b0; stale_done = 1'b0;
      tick(); tick();
      n_checks++;
      if ({ReqReady, FibRst, FibStart, RspValid, RspErr, Busy} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 000000 (ReqReady,FibRst,FibStart,RspValid,RspErr,Busy)",
                  {ReqReady, FibRst, FibStart, RspValid, RspErr, Busy});
      end
      n_checks++;
      if (FibNumber !== 10'd0) begin
         n_fail++; $display("FAIL reset_fibnumber: got %0d want 0", FibNumber);
      end
      n_checks++;
      if ({RspNumber, RspResult} !== 20'd0) begin
         n_fail++; $display("FAIL reset_rsp: got number %0d result %0d want 0 0", RspNumber, RspResult);
      end
      Rst_n = 1'b1;
      tick();
      n_checks++;
      if (ReqReady !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready_after: got %b want 1", ReqReady);
      end
   endtask

   task automatic test_single();
      int n;
      int pulses;
      stub_lat = 3; ReqValid = 1'b1; ReqNumber = 10'd10;
      tick();
      ReqValid = 1'b0;
      n_checks++;
      if ({FibRst, FibStart, Busy, ReqReady} !== 4'b1010 || FibNumber !== 10'd10) begin
         n_fail++;
         $display("FAIL single_accept: got rst/start/busy/ready %b number %0d want 1010 10",
                  {FibRst, FibStart, Busy, ReqReady}, FibNumber);
      end
      pulses = 1;
      n = 0;
      while (!RspValid && n < 20) begin
         tick();
         n++;
         if (FibRst) pulses++;
         if (n == 1) begin
            n_checks++;
            if ({FibRst, FibStart} !== 2'b01) begin
               n_fail++; $display("FAIL single_run_entry: got rst/start %b want 01", {FibRst, FibStart});
            end
         end
      end
      n_checks++;
      if (n != 5) begin
         n_fail++; $display("FAIL single_latency: got %0d cycles want 5", n);
      end
      n_checks++;
      if (pulses != 1) begin
         n_fail++; $display("FAIL single_rst_pulses: got %0d want 1", pulses);
      end
      n_checks++;
      if (RspNumber !== 10'd10 || RspResult !== 10'd20 || RspErr !== 1'b0) begin
         n_fail++;
         $display("FAIL single_rsp: got %0d/%0d/%b want 10/20/0", RspNumber, RspResult, RspErr);
      end
      n_checks++;
      if ({FibStart, Busy, ReqReady} !== 3'b001) begin
         n_fail++; $display("FAIL single_done_state: got start/busy/ready %b want 001", {FibStart, Busy, ReqReady});
      end
      RspReady = 1'b1; tick(); RspReady = 1'b0;
      n_checks++;
      if (RspValid !== 1'b0) begin
         n_fail++; $display("FAIL single_pop: got RspValid %b want 0", RspValid);
      end
   endtask

   task automatic test_fifo_full();
      int n;
      int ready_seen;
      RspReady = 1'b0; stub_lat = 1;
      for (int k = 1; k <= 4; k++) begin
         ReqValid = 1'b1; ReqNumber = DW'(k);
         n = 0;
         while (!ReqReady && n < 20) begin tick(); n++; end
         n_checks++;
         if (ReqReady !== 1'b1) begin
            n_fail++; $display("FAIL full_wait_ready: job %0d got ReqReady %b want 1", k, ReqReady);
         end
         tick();
         n_checks++;
         if (FibNumber !== DW'(k)) begin
            n_fail++; $display("FAIL full_accept: got %0d want %0d", FibNumber, k);
         end
      end
      ReqNumber = 10'd5;
      ready_seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (ReqReady) ready_seen++;
      end
      n_checks++;
      if (ready_seen != 0) begin
         n_fail++; $display("FAIL full_ready_low: got %0d ready cycles want 0", ready_seen);
      end
      n_checks++;
      if ({RspValid, Busy} !== 2'b10 || RspNumber !== 10'd1 || RspResult !== 10'd2) begin
         n_fail++;
         $display("FAIL full_head: got valid/busy %b head %0d/%0d want 10 1/2", {RspValid, Busy}, RspNumber, RspResult);
      end
      RspReady = 1'b1; tick(); RspReady = 1'b0;
      n_checks++;
      if (ReqReady !== 1'b1) begin
         n_fail++; $display("FAIL full_ready_after_pop: got %b want 1", ReqReady);
      end
      tick();
      ReqValid = 1'b0;
      n_checks++;
      if (FibNumber !== 10'd5 || FibRst !== 1'b1) begin
         n_fail++; $display("FAIL full_accept5: got number %0d rst %b want 5 1", FibNumber, FibRst);
      end
      for (int k = 2; k <= 5; k++) begin
         n = 0;
         while (!RspValid && n < 20) begin tick(); n++; end
         n_checks++;
         if (RspValid !== 1'b1 || RspNumber !== DW'(k) || RspResult !== DW'(2*k)) begin
            n_fail++;
            $display("FAIL full_drain: got valid %b %0d/%0d want 1 %0d/%0d", RspValid, RspNumber, RspResult, k, 2*k);
         end
         RspReady = 1'b1; tick(); RspReady = 1'b0;
      end
      n_checks++;
      if (RspValid !== 1'b0) begin
         n_fail++; $display("FAIL full_empty: got RspValid %b want 0", RspValid);
      end
   endtask

   task automatic test_stale_done();
      int n;
      stale_done = 1'b1; stub_lat = 4;
      ReqValid = 1'b1; ReqNumber = 10'd7;
      tick();
      ReqValid = 1'b0;
      tick(); tick();
      stale_done = 1'b0;
      n_checks++;
      if ({RspValid, Busy, FibStart} !== 3'b011) begin
         n_fail++; $display("FAIL stale_ignored: got valid/busy/start %b want 011", {RspValid, Busy, FibStart});
      end
      n = 0;
      while (!RspValid && n < 20) begin tick(); n++; end
      n_checks++;
      if (RspValid !== 1'b1 || RspNumber !== 10'd7 || RspResult !== 10'd14 || RspErr !== 1'b0) begin
         n_fail++;
         $display("FAIL stale_rsp: got valid %b %0d/%0d/%b want 1 7/14/0", RspValid, RspNumber, RspResult, RspErr);
      end
      RspReady = 1'b1; tick(); RspReady = 1'b0;
   endtask

   task automatic test_back_to_back();
      RspReady = 1'b0; stub_lat = 1;
      ReqValid = 1'b1; ReqNumber = 10'd11;
      tick();
      n_checks++;
      if (FibNumber !== 10'd11) begin
         n_fail++; $display("FAIL b2b_accept11: got %0d want 11", FibNumber);
      end
      ReqNumber = 10'd12;
      tick(); tick(); tick();
      n_checks++;
      if ({ReqReady, Busy, RspValid} !== 3'b101) begin
         n_fail++; $display("FAIL b2b_turnaround: got ready/busy/valid %b want 101", {ReqReady, Busy, RspValid});
      end
      tick();
      ReqValid = 1'b0;
      n_checks++;
      if (FibNumber !== 10'd12 || FibRst !== 1'b1) begin
         n_fail++; $display("FAIL b2b_accept12: got number %0d rst %b want 12 1", FibNumber, FibRst);
      end
      tick(); tick(); tick();
      ReqValid = 1'b1; ReqNumber = 10'd13;
      tick();
      ReqValid = 1'b0;
      tick(); tick();
      n_checks++;
      if (Busy !== 1'b1 || RspNumber !== 10'd11 || RspResult !== 10'd22) begin
         n_fail++; $display("FAIL b2b_before_pushpop: got busy %b head %0d/%0d want 1 11/22", Busy, RspNumber, RspResult);
      end
      RspReady = 1'b1; tick(); RspReady = 1'b0;
      n_checks++;
      if ({Busy, RspValid} !== 2'b01 || RspNumber !== 10'd12 || RspResult !== 10'd24) begin
         n_fail++;
         $display("FAIL b2b_pushpop_head: got busy/valid %b head %0d/%0d want 01 12/24", {Busy, RspValid}, RspNumber, RspResult);
      end
      RspReady = 1'b1; tick(); RspReady = 1'b0;
      n_checks++;
      if (RspValid !== 1'b1 || RspNumber !== 10'd13 || RspResult !== 10'd26) begin
         n_fail++; $display("FAIL b2b_second: got valid %b %0d/%0d want 1 13/26", RspValid, RspNumber, RspResult);
      end
      RspReady = 1'b1; tick(); RspReady = 1'b0;
      n_checks++;
      if (RspValid !== 1'b0) begin
         n_fail++; $display("FAIL b2b_empty: got RspValid %b want 0", RspValid);
      end
   endtask

   task automatic test_reset_mid_job();
      int n;
      int seen;
      RspReady = 1'b0; stub_lat = 1;
      for (int k = 21; k <= 23; k++) begin
         ReqValid = 1'b1; ReqNumber = DW'(k);
         n = 0;
         while (!ReqReady && n < 20) begin tick(); n++; end
         if (k == 23) stub_lat = 20;
         tick();
      end
      ReqValid = 1'b0;
      tick(); tick();
      n_checks++;
      if ({Busy, FibStart, RspValid} !== 3'b111 || FibNumber !== 10'd23) begin
         n_fail++;
         $display("FAIL midrst_pre: got busy/start/valid %b number %0d want 111 23", {Busy, FibStart, RspValid}, FibNumber);
      end
      Rst_n = 1'b0;
      tick();
      n_checks++;
      if ({RspValid, Busy, FibStart, FibRst, ReqReady} !== 5'b0) begin
         n_fail++;
         $display("FAIL midrst_state: got valid/busy/start/rst/ready %b want 00000", {RspValid, Busy, FibStart, FibRst, ReqReady});
      end
      Rst_n = 1'b1;
      tick();
      n_checks++;
      if (ReqReady !== 1'b1) begin
         n_fail++; $display("FAIL midrst_ready: got %b want 1", ReqReady);
      end
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (RspValid) seen++;
      end
      n_checks++;
      if (seen != 0) begin
         n_fail++; $display("FAIL midrst_no_rsp: got %0d valid cycles want 0", seen);
      end
      stub_lat = 2; ReqValid = 1'b1; ReqNumber = 10'd9;
      tick();
      ReqValid = 1'b0;
      n = 0;
      while (!RspValid && n < 20) begin tick(); n++; end
      n_checks++;
      if (RspValid !== 1'b1 || RspNumber !== 10'd9 || RspResult !== 10'd18) begin
         n_fail++; $display("FAIL midrst_recover: got valid %b %0d/%0d want 1 9/18", RspValid, RspNumber, RspResult);
      end
      RspReady = 1'b1; tick(); RspReady = 1'b0;
   endtask

`ifdef FIB_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      stub_lat = 0; ReqValid = 1'b1; ReqNumber = 10'd30;
      tick();
      ReqValid = 1'b0;
      n = 0;
      while (!RspValid && n < 30) begin tick(); n++; end
      n_checks++;
      if (n != 9) begin
         n_fail++; $display("FAIL timeout_latency: got %0d cycles want 9", n);
      end
      n_checks++;
      if (RspValid !== 1'b1 || RspNumber !== 10'd30 || RspResult !== 10'd0 || RspErr !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_rsp: got valid %b %0d/%0d/%b want 1 30/0/1", RspValid, RspNumber, RspResult, RspErr);
      end
      RspReady = 1'b1; tick(); RspReady = 1'b0;
      stub_lat = 2; ReqValid = 1'b1; ReqNumber = 10'd31;
      tick();
      ReqValid = 1'b0;
      n = 0;
      while (!RspValid && n < 20) begin tick(); n++; end
      n_checks++;
      if (RspValid !== 1'b1 || RspNumber !== 10'd31 || RspResult !== 10'd62 || RspErr !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_next: got valid %b %0d/%0d/%b want 1 31/62/0", RspValid, RspNumber, RspResult, RspErr);
      end
      RspReady = 1'b1; tick(); RspReady = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_fifo_full();
      test_stale_done();
      test_back_to_back();
      test_reset_mid_job();
`ifdef FIB_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
